// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default baud divisor, receiver FSM
// states and the received-frame payload.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS    = 8;
  localparam int unsigned UART_DEFAULT_BAUD = 5210;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5,
    BREAK  = 3'd6
  } uart_state_e;

  typedef struct packed {
    logic [UART_DATA_BITS-1:0] data;
    logic                      parity_error;
    logic                      frame_error;
  } uart_rx_result_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: RX pin toward the receiver, decoded frame back out.
interface uart_rx_if;
  import uart_pkg::*;

  logic                      serial_data_in;
  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      parity_error;
  logic                      frame_error;
  logic                      rx_busy;

  modport master (
    output serial_data_in,
    input  rx_data, rx_valid, parity_error, frame_error, rx_busy
  );

  modport slave (
    input  serial_data_in,
    output rx_data, rx_valid, parity_error, frame_error, rx_busy
  );

endinterface

// File: rtl/uart_rx_fsm.sv
// Receiver frame sequencer: walks start/data/parity/stop from timer ticks and
// emits single-cycle strobes that steer the datapath in uart_rx.
module uart_rx_fsm
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rx_s_i,
  input  logic half_tick_i,
  input  logic bit_tick_i,
  input  logic bit_last_i,
  input  logic stop_i,
  output logic timer_clr_c_o,
  output logic idx_clr_c_o,
  output logic shift_c_o,
  output logic parity_cap_c_o,
  output logic stop_cap_c_o,
  output logic busy_c_o
);

  uart_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_s_i) state_d = START;
      START:   if (half_tick_i) state_d = rx_s_i ? IDLE : DATA;
      DATA:    if (bit_tick_i && bit_last_i) state_d = PARITY;
      PARITY:  if (bit_tick_i) state_d = STOP;
      STOP:    if (bit_tick_i) state_d = DONE;
      DONE:    state_d = stop_i ? IDLE : BREAK;
      BREAK:   if (rx_s_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Idle holds the timer at zero only while the line is high, so the count
  // already runs on the first low cycle and the start midpoint lands at baud/2.
  always_comb begin
    timer_clr_c_o  = (state_q == IDLE) ? rx_s_i : (state_d != state_q);
    idx_clr_c_o    = (state_q == START) && (state_d == DATA);
    shift_c_o      = (state_q == DATA) && bit_tick_i;
    parity_cap_c_o = (state_q == PARITY) && bit_tick_i;
    stop_cap_c_o   = (state_q == STOP) && bit_tick_i;
    busy_c_o       = (state_d != IDLE);
  end

endmodule

// File: rtl/uart_rx.sv
// 8E1 UART receiver: pin synchronizer, bit-centre timer, shift register and
// registered frame outputs around the uart_rx_fsm sequencer.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned baud_rate = UART_DEFAULT_BAUD
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave rx_if
);

  localparam int unsigned DW    = UART_DATA_BITS;
  localparam int unsigned CNT_W = $clog2(baud_rate);
  localparam int unsigned IDX_W = 4;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(baud_rate / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(baud_rate - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DW - 1);

  logic            sync1_q, sync1_d, sync2_q, sync2_d;
  logic            rx_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic            parity_q, parity_d;
  logic            stop_q, stop_d;
  uart_rx_result_t res_q, res_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_busy_q, rx_busy_d;

  logic half_tick, bit_tick;
  logic timer_clr_c, idx_clr_c, shift_c, parity_cap_c, stop_cap_c, busy_c;

  assign rx_s      = sync2_q;
  assign half_tick = (cnt_q == HALF_CNT);
  assign bit_tick  = (cnt_q == LAST_CNT);

  uart_rx_fsm u_fsm (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_s_i         (rx_s),
    .half_tick_i    (half_tick),
    .bit_tick_i     (bit_tick),
    .bit_last_i     (idx_q == LAST_IDX),
    .stop_i         (stop_q),
    .timer_clr_c_o  (timer_clr_c),
    .idx_clr_c_o    (idx_clr_c),
    .shift_c_o      (shift_c),
    .parity_cap_c_o (parity_cap_c),
    .stop_cap_c_o   (stop_cap_c),
    .busy_c_o       (busy_c)
  );

  // Datapath next-state: outputs load on the stop sample so they are visible
  // in the DONE cycle together with rx_valid.
  always_comb begin
    sync1_d    = rx_if.serial_data_in;
    sync2_d    = sync1_q;
    cnt_d      = (timer_clr_c || bit_tick) ? '0 : cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    if (idx_clr_c) begin
      idx_d = '0;
    end else if (shift_c) begin
      idx_d = idx_q + IDX_W'(1);
    end
    shift_d    = shift_c ? {rx_s, shift_q[DW-1:1]} : shift_q;
    parity_d   = parity_cap_c ? rx_s : parity_q;
    stop_d     = stop_cap_c ? rx_s : stop_q;
    res_d      = res_q;
    if (stop_cap_c) begin
      res_d.data         = shift_q;
      res_d.parity_error = ^{shift_q, parity_q};
      res_d.frame_error  = ~rx_s;
    end
    rx_valid_d = stop_cap_c;
    rx_busy_d  = busy_c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      stop_q     <= 1'b0;
      res_q      <= '0;
      rx_valid_q <= 1'b0;
      rx_busy_q  <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      stop_q     <= stop_d;
      res_q      <= res_d;
      rx_valid_q <= rx_valid_d;
      rx_busy_q  <= rx_busy_d;
    end
  end

  assign rx_if.rx_data      = res_q.data;
  assign rx_if.parity_error = res_q.parity_error;
  assign rx_if.frame_error  = res_q.frame_error;
  assign rx_if.rx_valid     = rx_valid_q;
  assign rx_if.rx_busy      = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: directed and random 8E1 frames
// scored against a frame-level model of the expected byte and status.
module tb_uart_rx;

  localparam int unsigned BAUD = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if bus ();

  uart_rx #(.baud_rate(BAUD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_if (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    int         cyc;
  } rec_t;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  rec_t obs_q[$];
  exp_t exp_q[$];
  exp_t last_exp;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1)
      obs_q.push_back('{bus.rx_data, bus.parity_error, bus.frame_error, cyc});
  end

  // Frame-level expectation: data+parity must hold an even number of ones,
  // and the stop bit must be high.
  function automatic exp_t model(input logic [7:0] d, input logic par, input logic stop);
    exp_t r;
    int   ones;
    ones   = $countones(d) + (par ? 1 : 0);
    r.data = d;
    r.pe   = (ones % 2) != 0;
    r.fe   = (stop == 1'b0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    bus.serial_data_in = b;
    repeat (BAUD) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.serial_data_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, output int k);
    k = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stop);
    exp_q.push_back(model(d, par, stop));
  endtask

  task automatic compare_frames(input string tag);
    chk($sformatf("%s_count", tag), 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), 32'(obs_q[i].data), 32'(exp_q[i].data));
      chk($sformatf("%s_perr%0d", tag, i), 32'(obs_q[i].pe), 32'(exp_q[i].pe));
      chk($sformatf("%s_ferr%0d", tag, i), 32'(obs_q[i].fe), 32'(exp_q[i].fe));
    end
    if (exp_q.size() > 0) last_exp = exp_q[exp_q.size()-1];
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk($sformatf("%s_data", tag), 32'(bus.rx_data), 32'h00);
    chk($sformatf("%s_valid", tag), 32'(bus.rx_valid), 32'h0);
    chk($sformatf("%s_perr", tag), 32'(bus.parity_error), 32'h0);
    chk($sformatf("%s_ferr", tag), 32'(bus.frame_error), 32'h0);
    chk($sformatf("%s_busy", tag), 32'(bus.rx_busy), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         k;
    logic       busy_ok;
    logic       dropped;
    logic [7:0] d;
    logic       par;
    int         gap;

    bus.serial_data_in = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    align();
    idle(4);

    // Clean frame: valid lands 2 sync cycles + baud/2 + 10 bits + 1 after the pin edge.
    send_frame(8'hA5, 1'b0, 1'b1, k);
    idle(4);
    if (obs_q.size() > 0) chk("a5_valid_cycle", 32'(obs_q[0].cyc), 32'(k + 2 + 8 + 160 + 1));
    compare_frames("a5");

    // Wrong parity bit.
    send_frame(8'h3C, 1'b1, 1'b1, k);
    idle(4);
    compare_frames("3c_parity");

    // Stop bit low with the line held low afterwards: one frame, then a break wait.
    send_frame(8'h81, 1'b0, 1'b0, k);
    busy_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rx_busy !== 1'b1) busy_ok = 1'b0;
    end
    chk("break_busy_held", 32'(busy_ok), 32'h1);
    align();
    bus.serial_data_in = 1'b1;
    dropped = 1'b0;
    for (int i = 0; i < 8 && !dropped; i++) begin
      @(negedge clk);
      if (bus.rx_busy === 1'b0) dropped = 1'b1;
    end
    chk("break_release", 32'(dropped), 32'h1);
    align();
    idle(8);
    compare_frames("81_break");

    // Short low glitch on an idle line.
    bus.serial_data_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.serial_data_in = 1'b1;
    @(negedge clk);
    chk("glitch_busy_during", 32'(bus.rx_busy), 32'h1);
    dropped = 1'b0;
    for (int i = 0; i < 10 && !dropped; i++) begin
      @(negedge clk);
      if (bus.rx_busy === 1'b0) dropped = 1'b1;
    end
    chk("glitch_busy_release", 32'(dropped), 32'h1);
    align();
    idle(40);
    chk("glitch_no_valid", 32'(obs_q.size()), 32'h0);
    chk("glitch_data_held", 32'(bus.rx_data), 32'(last_exp.data));
    chk("glitch_ferr_held", 32'(bus.frame_error), 32'(last_exp.fe));
    obs_q.delete();

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b0, 1'b1, k);
    send_frame(8'hFF, 1'b0, 1'b1, k);
    send_frame(8'h55, 1'b0, 1'b1, k);
    idle(4);
    compare_frames("b2b");

    // Random bytes, random parity bit, random short idle gaps.
    for (int n = 0; n < 6; n++) begin
      d   = 8'($urandom);
      par = 1'($urandom_range(0, 1));
      gap = int'($urandom_range(0, 20));
      send_frame(d, par, 1'b1, k);
      if (gap > 0) idle(gap);
    end
    idle(4);
    compare_frames("rand");

    // Reset pulse in the middle of data bit 4.
    d = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    bus.serial_data_in = d[4];
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.serial_data_in = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    align();
    idle(200);
    chk("abort_no_frame", 32'(obs_q.size()), 32'h0);
    obs_q.delete();

    send_frame(8'h5A, 1'b0, 1'b1, k);
    idle(4);
    compare_frames("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
